// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-in/parallel-out deserialiser.
// Contents:
//   ORDER_LSB_FIRST / ORDER_MSB_FIRST : values for the LSB_FIRST parameter
//   out_state_t                       : output holding-register state (EMPTY / FULL)
package sipo_pkg;

  localparam bit ORDER_LSB_FIRST = 1'b1;
  localparam bit ORDER_MSB_FIRST = 1'b0;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_t;

endpackage

// File: rtl/sipo_deser_if.sv
// Serial input and valid/ready parallel output bundle for sipo_deser.
// Signals:
//   serial_in, in_valid : qualified serial bit stream into the deserialiser
//   out_data, out_valid : completed word from the holding register
//   out_ready           : consumer accepts the held word
// Modports:
//   master : bit source / word consumer side (bench or surrounding logic)
//   slave  : the deserialiser itself
interface sipo_deser_if #(
  parameter int WIDTH = 8
);

  logic             serial_in;
  logic             in_valid;
  logic             out_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;

  modport master (
    output serial_in,
    output in_valid,
    output out_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  serial_in,
    input  in_valid,
    input  out_ready,
    output out_valid,
    output out_data
  );

endinterface

// File: rtl/sipo_shift_core.sv
// Shift register, bit counter and direction mux of the deserialiser.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   clear       : framing restart, drops the partial word (beats shifting)
//   serial_in   : serial bit, used only when in_valid=1
//   in_valid    : qualifies serial_in
//   word        : post-shift value of the register this cycle (valid when word_done=1)
//   bit_cnt     : bits collected in the current partial word
//   word_done   : combinational pulse, the final bit of a word is being sampled now
module sipo_shift_core #(
  parameter  int WIDTH     = 8,
  parameter  bit LSB_FIRST = 1'b1,
  localparam int CW        = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             serial_in,
  input  logic             in_valid,
  output logic [WIDTH-1:0] word,
  output logic [CW-1:0]    bit_cnt,
  output logic             word_done
);

  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  logic [WIDTH-1:0] shift_reg, shift_next;
  logic [WIDTH-1:0] shifted;
  logic [CW-1:0]    cnt_reg, cnt_next;

  generate
    if (LSB_FIRST) begin : g_lsb_first
      // Bits enter at the top and walk down, so the first bit ends in bit 0.
      assign shifted = {serial_in, shift_reg[WIDTH-1:1]};
    end else begin : g_msb_first
      assign shifted = {shift_reg[WIDTH-2:0], serial_in};
    end
  endgenerate

  assign word_done = in_valid & ~clear & (cnt_reg == LAST_CNT);
  assign word      = shifted;
  assign bit_cnt   = cnt_reg;

  always_comb begin
    shift_next = shift_reg;
    cnt_next   = cnt_reg;
    if (clear) begin
      shift_next = '0;
      cnt_next   = '0;
    end else if (in_valid) begin
      shift_next = shifted;
      // Explicit wrap: WIDTH need not be a power of two.
      cnt_next   = word_done ? '0 : cnt_reg + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_reg <= '0;
      cnt_reg   <= '0;
    end else begin
      shift_reg <= shift_next;
      cnt_reg   <= cnt_next;
    end
  end

endmodule

// File: rtl/sipo_deser.sv
// Parametrised serial-in/parallel-out deserialiser with a one-word holding register.
// Ports:
//   clk, reset : clock, synchronous active-high reset (clears all state)
//   clear      : framing restart; drops the partial word, holding register untouched
//   bus        : sipo_deser_if slave (serial_in/in_valid in, out_data/out_valid/out_ready)
//   bit_cnt    : bits collected in the current partial word
//   overrun    : sticky, a completed word was dropped because the holding register was full
module sipo_deser
  import sipo_pkg::*;
#(
  parameter  int WIDTH     = 8,
  parameter  bit LSB_FIRST = ORDER_LSB_FIRST,
  localparam int CW        = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  sipo_deser_if.slave   bus,
  output logic [CW-1:0] bit_cnt,
  output logic          overrun
);

  logic [WIDTH-1:0] word;
  logic             word_done;

  out_state_t       state_reg, state_next;
  logic [WIDTH-1:0] data_reg, data_next;
  logic             overrun_reg, overrun_next;

  sipo_shift_core #(
    .WIDTH     (WIDTH),
    .LSB_FIRST (LSB_FIRST)
  ) u_core (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .serial_in (bus.serial_in),
    .in_valid  (bus.in_valid),
    .word      (word),
    .bit_cnt   (bit_cnt),
    .word_done (word_done)
  );

  always_comb begin
    state_next   = state_reg;
    data_next    = data_reg;
    overrun_next = overrun_reg;
    case (state_reg)
      ST_EMPTY: begin
        if (word_done) begin
          data_next  = word;
          state_next = ST_FULL;
        end
      end
      ST_FULL: begin
        if (word_done) begin
          // Accept and reload in the same cycle keeps the port busy with no bubble.
          if (bus.out_ready) data_next = word;
          else               overrun_next = 1'b1;
        end else if (bus.out_ready) begin
          state_next = ST_EMPTY;
        end
      end
      default: state_next = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_EMPTY;
      data_reg    <= '0;
      overrun_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      data_reg    <= data_next;
      overrun_reg <= overrun_next;
    end
  end

  assign bus.out_valid = (state_reg == ST_FULL);
  assign bus.out_data  = data_reg;
  assign overrun       = overrun_reg;

endmodule

// File: tb/tb_sipo_deser.sv
// Self-checking bench for sipo_deser: an LSB-first and an MSB-first instance (WIDTH=8)
// share one stimulus stream; a word-level reference model predicts every output each cycle.
module tb_sipo_deser;

  localparam int W = 8;

  logic clk = 1'b0;
  logic s_reset, s_clear, s_bit, s_valid, s_ready;
  logic [2:0] cnt_l, cnt_m;
  logic ovr_l, ovr_m;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int         m_cnt;
  logic [7:0] m_acc_l, m_acc_m;
  logic [7:0] m_hold_l, m_hold_m;
  logic       m_full, m_ovr;

  always #5 clk = ~clk;

  sipo_deser_if #(.WIDTH(W)) if_l ();
  sipo_deser_if #(.WIDTH(W)) if_m ();

  assign if_l.serial_in = s_bit;
  assign if_l.in_valid  = s_valid;
  assign if_l.out_ready = s_ready;
  assign if_m.serial_in = s_bit;
  assign if_m.in_valid  = s_valid;
  assign if_m.out_ready = s_ready;

  sipo_deser #(.WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .reset(s_reset), .clear(s_clear), .bus(if_l.slave),
    .bit_cnt(cnt_l), .overrun(ovr_l)
  );

  sipo_deser #(.WIDTH(W), .LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .reset(s_reset), .clear(s_clear), .bus(if_m.slave),
    .bit_cnt(cnt_m), .overrun(ovr_m)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_acc_l = '0; m_acc_m = '0;
    m_hold_l = '0; m_hold_m = '0; m_full = 1'b0; m_ovr = 1'b0;
  endtask

  // Word-level view: the k-th bit of a word has weight 2^k (LSB-first) or 2^(7-k) (MSB-first).
  task automatic model_edge(input logic b, v, r, c, rs);
    logic       done;
    logic [7:0] new_l, new_m;
    if (rs) begin
      model_reset();
      return;
    end
    done  = v && !c && (m_cnt == W - 1);
    new_l = m_acc_l | (8'(b) << m_cnt);
    new_m = m_acc_m | (8'(b) << (W - 1 - m_cnt));
    if (done) begin
      if (!m_full || r) begin
        m_hold_l = new_l; m_hold_m = new_m; m_full = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (m_full && r) begin
      m_full = 1'b0;
    end
    if (c) begin
      m_cnt = 0; m_acc_l = '0; m_acc_m = '0;
    end else if (v) begin
      if (done) begin
        m_cnt = 0; m_acc_l = '0; m_acc_m = '0;
      end else begin
        m_cnt++; m_acc_l = new_l; m_acc_m = new_m;
      end
    end
  endtask

  task automatic compare_all();
    check("lsb_valid", if_l.out_valid, m_full);
    check("lsb_data",  if_l.out_data,  m_hold_l);
    check("lsb_cnt",   cnt_l,          m_cnt);
    check("lsb_ovr",   ovr_l,          m_ovr);
    check("msb_valid", if_m.out_valid, m_full);
    check("msb_data",  if_m.out_data,  m_hold_m);
    check("msb_cnt",   cnt_m,          m_cnt);
    check("msb_ovr",   ovr_m,          m_ovr);
  endtask

  task automatic step(input logic b, v, r, c, rs);
    s_bit = b; s_valid = v; s_ready = r; s_clear = c; s_reset = rs;
    @(posedge clk);
    model_edge(b, v, r, c, rs);
    #1;
    compare_all();
  endtask

  // Sends data[0] first; optional random idle gaps between bits.
  task automatic send_word(input logic [7:0] data, input logic r, input bit gaps);
    logic [2:0] frozen;
    for (int i = 0; i < W; i++) begin
      if (gaps) begin
        for (int g = 0; g < 3; g++) begin
          if ($urandom_range(0, 1) == 1) begin
            frozen = cnt_l;
            step(1'($urandom), 1'b0, r, 1'b0, 1'b0);
            check("gap_cnt_frozen", cnt_l, frozen);
          end
        end
      end
      step(data[i], 1'b1, r, 1'b0, 1'b0);
    end
  endtask

  initial begin
    model_reset();
    s_bit = 0; s_valid = 0; s_ready = 0; s_clear = 0; s_reset = 1;
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    check("reset_valid", if_l.out_valid, 1'b0);
    check("reset_data",  if_l.out_data,  8'h00);

    // 1: A5 with consumer ready, valid for exactly one cycle
    send_word(8'hA5, 1'b1, 1'b0);
    check("t1_data", if_l.out_data, 8'hA5);
    check("t1_valid", if_l.out_valid, 1'b1);
    check("t1_cnt", cnt_l, 3'd0);
    step(0, 0, 1, 0, 0);
    check("t1_valid_drop", if_l.out_valid, 1'b0);

    // 2: symmetric pattern gives 3C in both bit orders
    send_word(8'h3C, 1'b1, 1'b0);
    check("t2_lsb", if_l.out_data, 8'h3C);
    check("t2_msb", if_m.out_data, 8'h3C);
    step(0, 0, 1, 0, 0);

    // 3: held consumer, second word dropped and overrun set
    send_word(8'h11, 1'b0, 1'b0);
    send_word(8'h22, 1'b0, 1'b0);
    check("t3_data_kept", if_l.out_data, 8'h11);
    check("t3_overrun", ovr_l, 1'b1);
    step(0, 0, 1, 0, 0);
    check("t3_valid_drop", if_l.out_valid, 1'b0);
    check("t3_overrun_sticky", ovr_l, 1'b1);

    // 4: random gaps between bits
    send_word(8'hC3, 1'b1, 1'b1);
    check("t4_data", if_l.out_data, 8'hC3);
    step(0, 0, 1, 0, 0);

    // 5: clear mid-word (with in_valid=1), then back-to-back words
    step(0, 0, 0, 0, 1);
    step(1, 1, 1, 0, 0);
    step(1, 1, 1, 0, 0);
    step(1, 1, 1, 0, 0);
    step(1, 1, 1, 1, 0);
    check("t5_clear_cnt", cnt_l, 3'd0);
    send_word(8'h5A, 1'b1, 1'b0);
    check("t5_data", if_l.out_data, 8'h5A);
    send_word(8'h01, 1'b1, 1'b0);
    check("t5_w1_lsb", if_l.out_data, 8'h01);
    check("t5_w1_msb", if_m.out_data, 8'h80);
    send_word(8'h02, 1'b1, 1'b0);
    check("t5_w2", if_l.out_data, 8'h02);
    check("t5_no_overrun", ovr_l, 1'b0);
    step(0, 0, 1, 0, 0);

    // 6: reset mid-word and while full
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    check("t6_cnt_zero", cnt_l, 3'd0);
    send_word(8'hFF, 1'b0, 1'b0);
    check("t6_full", if_l.out_valid, 1'b1);
    step(0, 0, 0, 0, 1);
    check("t6_valid_zero", if_l.out_valid, 1'b0);
    check("t6_data_zero", if_l.out_data, 8'h00);
    send_word(8'hFF, 1'b1, 1'b0);
    check("t6_data", if_l.out_data, 8'hFF);

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      step(1'($urandom),
           $urandom_range(0, 3) != 0,
           1'($urandom),
           $urandom_range(0, 39) == 0,
           $urandom_range(0, 199) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
